// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the memory arbiter of the 5-stage pipeline.
package pipeline_pkg;

    // Arbiter FSM states, 3-bit encoding visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_D = 3'd1,
        ST_ISSUE_I = 3'd2,
        ST_WAIT_D  = 3'd3,
        ST_WAIT_I  = 3'd4
    } state_t;

    // Port identifiers used for the round-robin last-grant bit.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Default number of cycles a bus transaction may stay outstanding.
    localparam int MAX_WAIT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_bus_watchdog.sv
// bus_watchdog: saturating cycle counter that flags an outstanding bus
// transaction once it has been pending for MAX_WAIT cycles.
import pipeline_pkg::*;

module bus_watchdog #(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between the instruction
// fetch port and the data port, one transaction in flight, alternating grant
// under contention, with fetch kill on redirect and a bus timeout.
//
// Bus handshake: mem_req and its fields are registered and held stable until
// a cycle in which mem_gnt is high (transfer accepted on mem_req & mem_gnt);
// mem_rvalid is then a single-cycle response strobe (read data or write ack)
// for that accepted request, with no back-pressure from the arbiter.
import pipeline_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    // instruction fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                flush,
    // data port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                d_stall,
    // memory bus
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err,
    // debug
    output state_t              dbg_state_o
);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  kill_q, kill_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_W/8-1:0]   mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
    logic                  if_done_q, if_done_d;
    logic                  d_done_q, d_done_d;
    logic                  bus_err_q, bus_err_d;

    logic                  wd_clear, wd_enable, wd_expired;
    logic                  if_pend, d_pend, pick_d, on_d_port, killed;

    // A requester whose done pulse is high this cycle is still holding its
    // old request, so it is not eligible until the following cycle.
    assign if_pend   = if_req & ~if_done_q;
    assign d_pend    = d_req & ~d_done_q;
    assign pick_d    = d_pend & (~if_pend | (last_grant_q == PORT_IF));
    assign on_d_port = (state_q == ST_ISSUE_D) || (state_q == ST_WAIT_D);
    assign killed    = kill_q | flush;

    bus_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Next-state, bus request fields and completion outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        kill_d       = kill_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        bus_err_d    = bus_err_q;
        wd_clear     = 1'b0;
        wd_enable    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                kill_d   = 1'b0;
                wd_clear = 1'b1;
                if (pick_d) begin
                    state_d     = ST_ISSUE_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_pend) begin
                    state_d     = ST_ISSUE_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            ST_ISSUE_D, ST_ISSUE_I: begin
                wd_enable = 1'b1;
                if (!on_d_port && flush) kill_d = 1'b1;
                if (mem_gnt) begin
                    mem_req_d    = 1'b0;
                    state_d      = on_d_port ? ST_WAIT_D : ST_WAIT_I;
                    last_grant_d = on_d_port ? PORT_D : PORT_IF;
                end
            end
            ST_WAIT_D, ST_WAIT_I: begin
                wd_enable = 1'b1;
                if (!on_d_port && flush) kill_d = 1'b1;
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    if (on_d_port) begin
                        if (!mem_we_q) d_rdata_d = mem_rdata;
                        d_done_d = 1'b1;
                    end else if (!killed) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout overrides whatever the bus did this cycle: the requester
        // gets a zero word and a done pulse, and the error sticks.
        if ((state_q != ST_IDLE) && wd_expired) begin
            state_d      = ST_IDLE;
            mem_req_d    = 1'b0;
            bus_err_d    = 1'b1;
            last_grant_d = last_grant_q;
            if (on_d_port) begin
                d_rdata_d = '0;
                d_done_d  = 1'b1;
            end else if (!killed) begin
                if_rdata_d = '0;
                if_done_d  = 1'b1;
            end
        end
    end

    // State and output registers; reset drops any transaction silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT_IF;
            kill_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            kill_q       <= kill_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign if_done     = if_done_q;
    assign d_rdata     = d_rdata_q;
    assign d_done      = d_done_q;
    assign bus_err     = bus_err_q;
    assign if_stall    = if_req & ~if_done_q;
    assign d_stall     = d_req & ~d_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, hand-written corner sequences and a
// randomized two-requester run against a behavioural bus and memory model.
module tb_mem_arbiter;
    import pipeline_pkg::*;

    localparam int MAXW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req, flush, d_req, d_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_done, if_stall, d_done, d_stall, mem_req, mem_we, bus_err;
    logic [3:0]  mem_be;
    state_t      dbg_state;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall), .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .bus_err(bus_err), .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [67:0] exp_q[$];                    // expected store {addr, be, wdata}
    bit          glog[$];                     // grant order, 1 = data port
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          slave_en;
    int          gnt_max, rv_max;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] w);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // ---------------- behavioural bus slave ----------------
    initial begin : bus_slave
        int g_wait, g_target, r_wait;
        bit in_flight;
        logic [31:0] resp, old;
        logic [67:0] exp;
        g_wait = 0; g_target = 0; r_wait = 0; in_flight = 0; resp = '0;
        forever begin
            @(negedge clk);
            if (!slave_en || !rst_n) begin
                in_flight = 0;
                g_wait = 0;
            end else begin
                mem_gnt = 1'b0;
                mem_rvalid = 1'b0;
                if (in_flight) begin
                    check("mem_req_while_outstanding", mem_req, 1'b0);
                    if (r_wait == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = resp;
                        in_flight = 0;
                    end else r_wait--;
                end else if (mem_req) begin
                    if (g_wait >= g_target) begin
                        mem_gnt = 1'b1;
                        in_flight = 1;
                        g_wait = 0;
                        r_wait = $urandom_range(0, rv_max);
                        glog.push_back(mem_addr >= 32'h1000);
                        if (mem_we) begin
                            check("store_expected", exp_q.size() != 0, 1'b1);
                            if (exp_q.size() != 0) begin
                                exp = exp_q.pop_front();
                                check("store_bus_fields", {mem_addr, mem_be, mem_wdata}, exp);
                            end
                            old = slave_mem.exists(mem_addr) ? slave_mem[mem_addr] : init_word(mem_addr);
                            slave_mem[mem_addr] = merge(old, mem_be, mem_wdata);
                            resp = $urandom;
                        end else begin
                            resp = slave_mem.exists(mem_addr) ? slave_mem[mem_addr] : init_word(mem_addr);
                        end
                    end else g_wait++;
                end else begin
                    g_target = $urandom_range(0, gnt_max);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic if_txn(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
        bit done;
        if_req = 1'b1; if_addr = addr; lat = 0; done = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (if_done) done = 1;
            else check("if_stall_while_pending", if_stall, 1'b1);
        end
        check("if_done_seen", done, 1'b1);
        check("if_stall_at_done", if_stall, 1'b0);
        rdata = if_rdata;
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic d_txn(input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        bit done;
        if (we) begin
            exp_q.push_back({addr, be, wdata});
            ref_mem[addr] = merge(ref_read(addr), be, wdata);
        end
        d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        lat = 0; done = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (d_done) done = 1;
            else check("d_stall_while_pending", d_stall, 1'b1);
        end
        check("d_done_seen", done, 1'b1);
        check("d_stall_at_done", d_stall, 1'b0);
        rdata = d_rdata;
        @(negedge clk);
        d_req = 1'b0;
    endtask

    // Fetch whose result is discarded by a redirect; bus driven by hand.
    task automatic flush_seq(input bit coincident, input logic [31:0] addr);
        int n;
        slave_en = 0;
        if_req = 1'b1; if_addr = addr; n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 10);
        check("flush_fetch_issued", mem_req, 1'b1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        flush = !coincident;
        check("flush_in_wait_i", dbg_state, ST_WAIT_I);
        @(negedge clk);
        flush = coincident;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        check("flush_no_done_early", if_done, 1'b0);
        @(negedge clk);
        flush = 1'b0; mem_rvalid = 1'b0; if_req = 1'b0;
        check("flush_back_idle", dbg_state, ST_IDLE);
        for (int k = 0; k < 3; k++) begin
            check("flush_no_if_done", if_done, 1'b0);
            check("flush_if_rdata_kept", if_rdata, exp_if_rdata);
            @(negedge clk);
        end
        slave_en = 1;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin : main
        vec_t tbl[8];
        logic [31:0] r_if, r_d, a, w, e;
        int lat_if, lat_d, n;
        bit we;
        logic [3:0] be;

        if_req = 0; if_addr = 0; flush = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        slave_en = 1; gnt_max = 0; rv_max = 0;
        exp_if_rdata = 0; exp_d_rdata = 0;
        slave_mem[32'h100] = 32'h00000013;  ref_mem[32'h100] = 32'h00000013;
        slave_mem[32'h104] = 32'h00100093;  ref_mem[32'h104] = 32'h00100093;
        slave_mem[32'h2000] = 32'h12345678; ref_mem[32'h2000] = 32'h12345678;
        slave_mem[32'h2004] = 32'hFFFF0000; ref_mem[32'h2004] = 32'hFFFF0000;

        tbl[0] = '{1'b0, 1'b0, 4'hF, 32'h100,  32'h0,        32'h00000013};
        tbl[1] = '{1'b1, 1'b0, 4'hF, 32'h2000, 32'h0,        32'h12345678};
        tbl[2] = '{1'b1, 1'b1, 4'h3, 32'h2004, 32'hAABBCCDD, 32'h12345678};
        tbl[3] = '{1'b1, 1'b0, 4'hF, 32'h2004, 32'h0,        32'hFFFFCCDD};
        tbl[4] = '{1'b0, 1'b0, 4'hF, 32'h104,  32'h0,        32'h00100093};
        tbl[5] = '{1'b1, 1'b1, 4'h8, 32'h2000, 32'h11223344, 32'hFFFFCCDD};
        tbl[6] = '{1'b1, 1'b0, 4'hF, 32'h2000, 32'h0,        32'h11345678};
        tbl[7] = '{1'b0, 1'b0, 4'hF, 32'h100,  32'h0,        32'h00000013};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_done", {if_done, d_done}, 2'b00);
        check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        check("rst_bus_err", bus_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // tie right after reset: data first, then fetch
        glog.delete();
        fork
            if_txn(32'h0, r_if, lat_if);
            d_txn(1'b0, 4'hF, 32'h2000, 32'h0, r_d, lat_d);
        join
        check("tie1_grants", glog.size(), 2);
        check("tie1_order", {glog[0], glog[1]}, 2'b10);
        check("tie1_d_lat", lat_d, 3);
        check("tie1_if_lat", lat_if, 6);
        check("tie1_d_rdata", r_d, 32'h12345678);
        check("tie1_if_rdata", r_if, init_word(32'h0));

        // data served last, so the next tie goes to fetch
        d_txn(1'b0, 4'hF, 32'h2000, 32'h0, r_d, lat_d);
        glog.delete();
        fork
            if_txn(32'h100, r_if, lat_if);
            d_txn(1'b0, 4'hF, 32'h2004, 32'h0, r_d, lat_d);
        join
        check("tie2_order", {glog[0], glog[1]}, 2'b01);
        check("tie2_if_lat", lat_if, 3);
        check("tie2_d_lat", lat_d, 6);
        check("tie2_d_rdata", r_d, 32'hFFFF0000);

        // directed vectors, zero-delay bus
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_d) d_txn(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, r_d, lat_d);
            else if_txn(tbl[i].addr, r_d, lat_d);
            check($sformatf("vec%0d_rdata", i), r_d, tbl[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), lat_d, 3);
            if (tbl[i].is_d) exp_d_rdata = tbl[i].exp_rdata;
            else exp_if_rdata = tbl[i].exp_rdata;
        end

        // killed fetches, then a normal fetch
        flush_seq(1'b0, 32'h200);
        flush_seq(1'b1, 32'h204);
        if_txn(32'h104, r_if, lat_if);
        check("post_flush_rdata", r_if, 32'h00100093);
        check("post_flush_latency", lat_if, 3);
        exp_if_rdata = 32'h00100093;

        // timeout: grant withheld
        slave_en = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008; lat_d = 0;
        while (!d_done && lat_d < 30) begin @(negedge clk); lat_d++; end
        check("to_done", d_done, 1'b1);
        check("to_latency", lat_d, MAXW + 2);
        check("to_d_rdata", d_rdata, 32'h0);
        check("to_bus_err", bus_err, 1'b1);
        check("to_state", dbg_state, ST_IDLE);
        check("to_mem_req", mem_req, 1'b0);
        @(negedge clk);
        d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12121212;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stray_no_done", {if_done, d_done}, 2'b00);
            check("stray_rdata", {if_rdata, d_rdata}, {exp_if_rdata, 32'h0});
            check("stray_bus_err", bus_err, 1'b1);
            @(negedge clk);
        end
        exp_d_rdata = 0;

        // reset during WAIT_D
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 10);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst2_in_wait_d", dbg_state, ST_WAIT_D);
        rst_n = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2_bus", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 70'h0);
        check("rst2_rdata", {if_rdata, d_rdata}, 64'h0);
        check("rst2_flags", {if_done, d_done, bus_err, if_stall, d_stall}, 5'b0);
        check("rst2_state", dbg_state, ST_IDLE);
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rst2_no_done", d_done, 1'b0);
            @(negedge clk);
        end
        exp_if_rdata = 0;
        slave_en = 1;
        d_txn(1'b0, 4'hF, 32'h2000, 32'h0, r_d, lat_d);
        check("rst2_reload", r_d, 32'h11345678);
        check("rst2_latency", lat_d, 3);
        exp_d_rdata = 32'h11345678;

        // randomized concurrent traffic
        gnt_max = 3; rv_max = 3;
        fork
            begin
                logic [31:0] fa, fe, fr;
                int fl;
                for (int i = 0; i < 40; i++) begin
                    fa = 32'($urandom_range(0, 1023)) << 2;
                    fe = ref_read(fa);
                    if_txn(fa, fr, fl);
                    check("rand_if_rdata", fr, fe);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    a = 32'h2000 + (32'($urandom_range(0, 63)) << 2);
                    we = 1'($urandom_range(0, 1));
                    be = 4'($urandom_range(1, 15));
                    w = $urandom;
                    e = we ? exp_d_rdata : ref_read(a);
                    d_txn(we, be, a, w, r_d, lat_d);
                    check("rand_d_rdata", r_d, e);
                    exp_d_rdata = e;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        check("rand_bus_err", bus_err, 1'b0);
        check("rand_stores_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard time limit
    initial begin
        #2000000;
        $display("FAIL global_time_limit reached at %0t", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
